// File: rtl/aes_ctr_feeder.sv
// aes_ctr_feeder
// CTR-mode wrapper around an iterative AES-128 core. Plaintext blocks are taken
// one at a time. The current counter block and the stored key go to the core
// with a one-cycle start pulse. The core result is XORed with the buffered
// plaintext and offered on a registered valid/ready output. A watchdog drops
// the block and raises a sticky flag if the core does not answer in time.
//
// state | meaning
// IDLE  | waiting for key/IV load or a plaintext block
// ISSUE | one-cycle start pulse to the core; counter advances on exit
// WAIT  | waiting for the core result; timeout timer running
// OUT   | ciphertext held on the output until the consumer accepts it

module aes_ctr_feeder #(
   parameter int CTR_WIDTH     = 32,
   parameter int CORE_LATENCY  = 11,
   parameter int TIMEOUT_SLACK = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         cfg_load_i,
   input  logic [127:0] cfg_key_i,
   input  logic [127:0] cfg_iv_i,
   input  logic         pt_valid_i,
   output logic         pt_ready_o,
   input  logic [127:0] pt_data_i,
   output logic         ct_valid_o,
   input  logic         ct_ready_i,
   output logic [127:0] ct_data_o,
   output logic         core_data_valid_o,
   output logic [127:0] core_data_o,
   output logic [127:0] core_key_o,
   input  logic [127:0] core_res_i,
   input  logic         core_res_valid_i,
   output logic         busy_o,
   output logic         err_timeout_o
);

   // Last WAIT-cycle timer value at which a missing result is declared lost.
   localparam int TMO_LAST = CORE_LATENCY + TIMEOUT_SLACK - 1;
   localparam int TIMER_W  = $clog2(TMO_LAST + 2);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TMO_LAST);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   logic [1:0]         state_q;
   logic [1:0]         state_d;
   logic               key_loaded_q;
   logic               err_q;
   logic [127:0]       key_q;
   logic [127:0]       ctr_q;
   logic [127:0]       pt_q;
   logic [127:0]       ct_q;
   logic [TIMER_W-1:0] timer_q;

   logic in_idle;
   logic load_take;
   logic pt_take;
   logic res_take;
   logic tmo_hit;
   logic ct_take;

   assign in_idle   = (state_q == S_IDLE);
   assign load_take = in_idle & cfg_load_i;
   assign pt_ready_o = in_idle & key_loaded_q & ~cfg_load_i;
   assign pt_take   = pt_valid_i & pt_ready_o;
   assign res_take  = (state_q == S_WAIT) & core_res_valid_i;
   // A result arriving on the expiry cycle wins over the timeout.
   assign tmo_hit   = (state_q == S_WAIT) & ~core_res_valid_i & (timer_q == TIMER_LAST);
   assign ct_take   = (state_q == S_OUT) & ct_ready_i;

   assign core_data_valid_o = (state_q == S_ISSUE);
   assign core_data_o       = ctr_q;
   assign core_key_o        = key_q;
   assign ct_valid_o        = (state_q == S_OUT);
   assign ct_data_o         = ct_q;
   assign busy_o            = ~in_idle;
   assign err_timeout_o     = err_q;

   // Next-state decode for the block sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pt_take) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (res_take)     state_d = S_OUT;
            else if (tmo_hit) state_d = S_IDLE;
         end
         S_OUT:   if (ct_take) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Key and key-loaded flag; only reloaded while idle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         key_q        <= '0;
         key_loaded_q <= 1'b0;
      end else if (load_take) begin
         key_q        <= cfg_key_i;
         key_loaded_q <= 1'b1;
      end
   end

   // Counter block: loaded from the IV, low CTR_WIDTH bits advance once per issued block.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ctr_q <= '0;
      end else if (load_take) begin
         ctr_q <= cfg_iv_i;
      end else if (state_q == S_ISSUE) begin
         ctr_q[CTR_WIDTH-1:0] <= ctr_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
      end
   end

   // Sticky timeout flag, cleared only by a fresh configuration load.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)        err_q <= 1'b0;
      else if (load_take) err_q <= 1'b0;
      else if (tmo_hit)   err_q <= 1'b1;
   end

   // Plaintext buffer for the block in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      pt_q <= '0;
      else if (pt_take) pt_q <= pt_data_i;
   end

   // Ciphertext register; holds steady through output backpressure.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)       ct_q <= '0;
      else if (res_take) ct_q <= core_res_i ^ pt_q;
   end

   // Core-response timer: restarted on issue, counts every WAIT cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                  timer_q <= '0;
      else if (state_q == S_ISSUE)  timer_q <= '0;
      else if (state_q == S_WAIT)   timer_q <= timer_q + TIMER_W'(1);
   end

endmodule

// File: tb/tb_aes_ctr_feeder.sv
// Bench for aes_ctr_feeder: behavioural AES core, CTR reference model and
// queue-based scoreboard checked by an independent monitor.
module tb_aes_ctr_feeder;

   localparam int CL    = 11;
   localparam int SLACK = 4;
   localparam int LMAX  = CL + SLACK;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         cfg_load_i = 1'b0;
   logic [127:0] cfg_key_i = '0;
   logic [127:0] cfg_iv_i = '0;
   logic         pt_valid_i = 1'b0;
   logic         pt_ready_o;
   logic [127:0] pt_data_i = '0;
   logic         ct_valid_o;
   logic         ct_ready_i = 1'b1;
   logic [127:0] ct_data_o;
   logic         core_data_valid_o;
   logic [127:0] core_data_o;
   logic [127:0] core_key_o;
   logic [127:0] core_res_i = '0;
   logic         core_res_valid_i = 1'b0;
   logic         busy_o;
   logic         err_timeout_o;

   aes_ctr_feeder #(.CTR_WIDTH(32), .CORE_LATENCY(CL), .TIMEOUT_SLACK(SLACK)) dut (
      .clk(clk), .resetn(resetn),
      .cfg_load_i(cfg_load_i), .cfg_key_i(cfg_key_i), .cfg_iv_i(cfg_iv_i),
      .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o), .pt_data_i(pt_data_i),
      .ct_valid_o(ct_valid_o), .ct_ready_i(ct_ready_i), .ct_data_o(ct_data_o),
      .core_data_valid_o(core_data_valid_o), .core_data_o(core_data_o), .core_key_o(core_key_o),
      .core_res_i(core_res_i), .core_res_valid_i(core_res_valid_i),
      .busy_o(busy_o), .err_timeout_o(err_timeout_o));

   always #5 clk = ~clk;

   int nvec = 0;
   int nfail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      nvec++;
      nfail++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // ---------------- AES-128 reference ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl8(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = (v << n) | (v >> (8 - n));
      return r;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h01;
         if (x == 0) inv = 8'h00;
         else for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
         sb[x] = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] blk);
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] s;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      s = blk ^ {w[0], w[1], w[2], w[3]};
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[rr+4*c] = b[rr+4*((c+rr)%4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[127-8*i -: 8] = t[i];
         s ^= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
      return s;
   endfunction

   // ---------------- core model ----------------
   int core_lat = CL;   // 0 = core never answers

   initial forever begin
      logic [127:0] d, k;
      int L;
      @(negedge clk);
      if (resetn && core_data_valid_o) begin
         d = core_data_o;
         k = core_key_o;
         L = core_lat;
         if (L != 0) begin
            repeat (L) @(posedge clk);
            #1;
            core_res_i = aes_enc(k, d);
            core_res_valid_i = 1'b1;
            @(posedge clk);
            #1;
            core_res_valid_i = 1'b0;
            core_res_i = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   // ---------------- output consumer ----------------
   int ct_mode = 0;   // 0 always ready, 1 random, 2 held low
   initial forever begin
      @(posedge clk);
      #2;
      case (ct_mode)
         0:       ct_ready_i = 1'b1;
         1:       ct_ready_i = 1'($urandom_range(0, 1));
         default: ct_ready_i = 1'b0;
      endcase
   end

   // ---------------- reference model + scoreboard ----------------
   typedef struct { logic [127:0] ct; int vcyc; } ct_exp_t;
   typedef struct { logic [127:0] d; logic [127:0] k; int pcyc; } pulse_exp_t;
   ct_exp_t    ctq[$];
   pulse_exp_t pq[$];

   logic [127:0] m_key = '0;
   logic [127:0] m_ctr = '0;
   bit           m_loaded = 0;
   bit           m_inflight = 0;
   bit           m_err = 0;
   int           m_to = -1;
   bit           ct_valid_prev = 0;
   logic [127:0] last_ct = '0;
   logic [127:0] last_core = '0;
   logic [127:0] last_key = '0;

   initial forever begin
      bit pre;
      bit exp_rdy;
      @(negedge clk);
      if (!resetn) begin
         chk("rst_outputs",
             {ct_valid_o, core_data_valid_o, pt_ready_o, busy_o, err_timeout_o},
             128'd0);
         chk("rst_data", ct_data_o | core_data_o | core_key_o, 128'd0);
         m_key = '0; m_ctr = '0; m_loaded = 0; m_inflight = 0; m_err = 0; m_to = -1;
         ctq.delete();
         pq.delete();
         ct_valid_prev = 0;
      end else begin
         pre = m_inflight;
         exp_rdy = m_loaded && !pre && !cfg_load_i;
         chk("pt_ready", pt_ready_o, exp_rdy);
         chk("busy", busy_o, pre);
         chk("err_timeout", err_timeout_o, m_err);

         if (core_data_valid_o) begin
            last_core = core_data_o;
            last_key  = core_key_o;
            if (pq.size() == 0) chk("pulse_unexpected", 1, 0);
            else begin
               chk("core_data", core_data_o, pq[0].d);
               chk("core_key", core_key_o, pq[0].k);
               chk("pulse_cycle", cyc, pq[0].pcyc);
               void'(pq.pop_front());
            end
         end

         if (ct_valid_o) begin
            if (ctq.size() == 0) chk("ct_unexpected", 1, 0);
            else begin
               if (!ct_valid_prev) chk("ct_latency", cyc, ctq[0].vcyc);
               chk("ct_data", ct_data_o, ctq[0].ct);
               if (ct_ready_i) begin
                  last_ct = ct_data_o;
                  void'(ctq.pop_front());
                  m_inflight = 0;
               end
            end
         end
         ct_valid_prev = ct_valid_o;

         if (pre && m_to == cyc) begin
            m_inflight = 0;
            m_err = 1;
            m_to = -1;
         end

         if (!pre && cfg_load_i) begin
            m_key = cfg_key_i;
            m_ctr = cfg_iv_i;
            m_loaded = 1;
            m_err = 0;
         end

         if (pt_valid_i && exp_rdy) begin
            pq.push_back('{d: m_ctr, k: m_key, pcyc: cyc + 1});
            if (core_lat >= 1 && core_lat <= LMAX) begin
               ctq.push_back('{ct: aes_enc(m_key, m_ctr) ^ pt_data_i, vcyc: cyc + 2 + core_lat});
               m_to = -1;
            end else begin
               m_to = cyc + 1 + LMAX;
            end
            m_ctr[31:0] = m_ctr[31:0] + 32'd1;
            m_inflight = 1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept();
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (pt_ready_o) begin
            tick();
            pt_valid_i = 1'b0;
            return;
         end
      end
      bound_fail("accept_wait");
      pt_valid_i = 1'b0;
   endtask

   task automatic send(input logic [127:0] pt);
      tick();
      pt_valid_i = 1'b1;
      pt_data_i = pt;
      wait_accept();
   endtask

   task automatic do_load(input logic [127:0] k, input logic [127:0] iv,
                          input bit with_pt, input logic [127:0] pt);
      tick();
      cfg_load_i = 1'b1;
      cfg_key_i = k;
      cfg_iv_i = iv;
      if (with_pt) begin
         pt_valid_i = 1'b1;
         pt_data_i = pt;
      end
      tick();
      cfg_load_i = 1'b0;
      cfg_key_i = {$urandom, $urandom, $urandom, $urandom};
      if (with_pt) wait_accept();
   endtask

   task automatic wait_done(input int budget);
      for (int n = 0; n < budget; n++) begin
         @(posedge clk);
         if (!m_inflight) begin
            #1;
            return;
         end
      end
      bound_fail("block_done");
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [127:0] k_fips, iv_fips, k_hold, wrap_iv;
      int waited;
      build_sbox();
      k_fips  = 128'h000102030405060708090a0b0c0d0e0f;
      iv_fips = 128'h00112233445566778899aabbccddeeff;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ct_valid", ct_valid_o, 0);
      chk("reset_pt_ready", pt_ready_o, 0);
      resetn = 1'b1;
      repeat (3) tick();

      // Known-answer block and counter increment.
      do_load(k_fips, iv_fips, 0, '0);
      send(128'd0);
      wait_done(40);
      chk("fips_core_data", last_core, iv_fips);
      chk("fips_ct", last_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      send(rnd128());
      wait_done(40);
      chk("ctr_incr", last_core, 128'h00112233445566778899aabbccddef00);

      // Counter wrap in the low 32 bits; load wins over a same-cycle plaintext.
      wrap_iv = {{12{8'hA5}}, 32'hffffffff};
      do_load(rnd128(), wrap_iv, 1, rnd128());
      wait_done(40);
      chk("wrap_first", last_core, wrap_iv);
      send(rnd128());
      wait_done(40);
      chk("wrap_second", last_core, {{12{8'hA5}}, 32'h00000000});

      // Output backpressure.
      ct_mode = 2;
      send(rnd128());
      waited = 0;
      while (!ct_valid_o && waited < 40) begin
         tick();
         waited++;
      end
      if (waited >= 40) bound_fail("ct_valid_wait");
      repeat (20) tick();
      chk("bp_valid_held", ct_valid_o, 1);
      ct_mode = 0;
      wait_done(10);

      // Configuration load while a block is in flight is ignored.
      k_hold = m_key;
      send(rnd128());
      repeat (3) tick();
      cfg_load_i = 1'b1;
      cfg_key_i = rnd128();
      cfg_iv_i = rnd128();
      tick();
      cfg_load_i = 1'b0;
      wait_done(40);
      send(rnd128());
      wait_done(40);
      chk("load_in_wait_ignored", last_key, k_hold);

      // Core never answers, then answers one cycle too late, then exactly at the limit.
      core_lat = 0;
      send(rnd128());
      wait_done(40);
      chk("timeout_flag", err_timeout_o, 1);
      chk("timeout_idle", busy_o, 0);
      core_lat = LMAX + 1;
      send(rnd128());
      wait_done(40);
      chk("late_result_dropped", err_timeout_o, 1);
      do_load(rnd128(), rnd128(), 0, '0);
      chk("load_clears_err", err_timeout_o, 0);
      core_lat = LMAX;
      send(rnd128());
      wait_done(40);
      chk("edge_result_no_err", err_timeout_o, 0);
      core_lat = CL;

      // Reset while waiting for the core; the stale result must be ignored.
      send(rnd128());
      repeat (4) tick();
      resetn = 1'b0;
      #1;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_core_data", core_data_o, 128'd0);
      repeat (3) tick();
      resetn = 1'b1;
      repeat (20) tick();
      chk("post_rst_ready", pt_ready_o, 0);

      // Randomised traffic.
      do_load(rnd128(), {rnd128() >> 32, 32'hfffffff0}, 0, '0);
      ct_mode = 1;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0:       core_lat = LMAX;
            1:       core_lat = 0;
            2:       core_lat = LMAX + 1;
            3:       core_lat = $urandom_range(1, LMAX);
            default: core_lat = CL;
         endcase
         send(rnd128());
         wait_done(80);
         repeat ($urandom_range(0, 3)) tick();
         if ($urandom_range(0, 7) == 0) do_load(rnd128(), rnd128(), $urandom_range(0, 1) == 1, rnd128());
         wait_done(80);
      end
      ct_mode = 0;
      repeat (30) tick();
      chk("queue_drained", 128'(ctq.size() + pq.size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
